// File: rtl/i2c_pkg.sv
// Shared I2C definitions: poller state encoding and ADT7420 register map.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ_MSB,
        WAIT_MSB,
        REQ_LSB,
        WAIT_LSB,
        UPDATE
    } poll_state_t;

    localparam logic [7:0] TEMP_MSB     = 8'h00;
    localparam logic [7:0] TEMP_LSB     = 8'h01;
    localparam logic [7:0] STATUS       = 8'h02;
    localparam logic [7:0] ID           = 8'h0B;
    localparam logic [6:0] ADT7420_ADDR = 7'h4B;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/i2c_temp_poller_if.sv
// Start/done handshake between the temperature poller and the I2C controller.
interface i2c_temp_poller_if;

    logic       ctrl_start;
    logic       ctrl_rw;
    logic [7:0] ctrl_addr;
    logic       ctrl_busy;
    logic       ctrl_done;
    logic       ctrl_error;
    logic [7:0] ctrl_rdata;

    modport master (
        output ctrl_start,
        output ctrl_rw,
        output ctrl_addr,
        input  ctrl_busy,
        input  ctrl_done,
        input  ctrl_error,
        input  ctrl_rdata
    );

    modport slave (
        input  ctrl_start,
        input  ctrl_rw,
        input  ctrl_addr,
        output ctrl_busy,
        output ctrl_done,
        output ctrl_error,
        output ctrl_rdata
    );

endinterface

// File: rtl/i2c_temp_poller.sv
// Periodic / on-demand ADT7420 temperature reader: fetches MSB then LSB through
// the controller handshake and publishes integer degrees plus sixteenths.
module i2c_temp_poller
    import i2c_pkg::*;
#(
    parameter int unsigned POLL_CYCLES = 25_000_000,
    parameter logic [7:0]  MSB_ADDR    = TEMP_MSB,
    parameter logic [7:0]  LSB_ADDR    = TEMP_LSB
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      poll_now,
    i2c_temp_poller_if.master         ctrl,
    output logic [15:0]               temp_raw,
    output logic [8:0]                temp_int,
    output logic [3:0]                temp_frac,
    output logic                      temp_valid,
    output logic                      poll_error,
    output logic [7:0]                err_count,
    output logic                      poller_busy
);

    localparam int unsigned CNT_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_CYCLES - 1);

    poll_state_t      state;
    logic [CNT_W-1:0] interval_cnt;
    logic [7:0]       msb_shadow;
    logic [7:0]       lsb_shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            interval_cnt    <= '0;
            msb_shadow      <= '0;
            lsb_shadow      <= '0;
            ctrl.ctrl_start <= 1'b0;
            ctrl.ctrl_rw    <= 1'b1;
            ctrl.ctrl_addr  <= MSB_ADDR;
            temp_raw        <= '0;
            temp_int        <= '0;
            temp_frac       <= '0;
            temp_valid      <= 1'b0;
            poll_error      <= 1'b0;
            err_count       <= '0;
            poller_busy     <= 1'b0;
        end else begin
            ctrl.ctrl_start <= 1'b0;
            temp_valid      <= 1'b0;
            poll_error      <= 1'b0;

            unique case (state)
                IDLE: begin
                    // Both triggers together still yield a single poll.
                    if (poll_now || (enable && interval_cnt == CNT_LAST)) begin
                        interval_cnt <= '0;
                        state        <= REQ_MSB;
                        poller_busy  <= 1'b1;
                    end else if (enable) begin
                        interval_cnt <= interval_cnt + 1'b1;
                    end else begin
                        interval_cnt <= '0;
                    end
                end

                REQ_MSB: begin
                    if (!ctrl.ctrl_busy) begin
                        ctrl.ctrl_start <= 1'b1;
                        ctrl.ctrl_addr  <= MSB_ADDR;
                        state           <= WAIT_MSB;
                    end
                end

                WAIT_MSB: begin
                    if (ctrl.ctrl_error) begin
                        poll_error  <= 1'b1;
                        err_count   <= sat_inc8(err_count);
                        state       <= IDLE;
                        poller_busy <= 1'b0;
                    end else if (ctrl.ctrl_done) begin
                        msb_shadow <= ctrl.ctrl_rdata;
                        state      <= REQ_LSB;
                    end
                end

                REQ_LSB: begin
                    if (!ctrl.ctrl_busy) begin
                        ctrl.ctrl_start <= 1'b1;
                        ctrl.ctrl_addr  <= LSB_ADDR;
                        state           <= WAIT_LSB;
                    end
                end

                WAIT_LSB: begin
                    if (ctrl.ctrl_error) begin
                        poll_error  <= 1'b1;
                        err_count   <= sat_inc8(err_count);
                        state       <= IDLE;
                        poller_busy <= 1'b0;
                    end else if (ctrl.ctrl_done) begin
                        lsb_shadow <= ctrl.ctrl_rdata;
                        state      <= UPDATE;
                    end
                end

                UPDATE: begin
                    // All three views load from the shadows together, so no
                    // consumer ever sees an old/new byte mix.
                    temp_raw    <= {msb_shadow, lsb_shadow};
                    temp_int    <= {msb_shadow, lsb_shadow[7]};
                    temp_frac   <= lsb_shadow[6:3];
                    temp_valid  <= 1'b1;
                    state       <= IDLE;
                    poller_busy <= 1'b0;
                end

                default: begin
                    state       <= IDLE;
                    poller_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_temp_poller.sv
// Directed bench for i2c_temp_poller with a behavioural I2C controller model.
module tb_i2c_temp_poller;

    localparam int unsigned POLL = 100;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        poll_now;
    logic [15:0] temp_raw;
    logic [8:0]  temp_int;
    logic [3:0]  temp_frac;
    logic        temp_valid;
    logic        poll_error;
    logic [7:0]  err_count;
    logic        poller_busy;

    i2c_temp_poller_if bus ();

    i2c_temp_poller #(
        .POLL_CYCLES (POLL),
        .MSB_ADDR    (8'h00),
        .LSB_ADDR    (8'h01)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .poll_now    (poll_now),
        .ctrl        (bus),
        .temp_raw    (temp_raw),
        .temp_int    (temp_int),
        .temp_frac   (temp_frac),
        .temp_valid  (temp_valid),
        .poll_error  (poll_error),
        .err_count   (err_count),
        .poller_busy (poller_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Controller model state, shared with the stimulus process.
    int          cyc = 0;
    int          lat_cfg = 2;
    int          lat_left = 0;
    bit          pending = 1'b0;
    bit          err_msb = 1'b0;
    bit          err_lsb = 1'b0;
    bit          busy_force = 1'b0;
    logic [7:0]  cur_addr = 8'h00;
    logic [7:0]  msb_val = 8'h00;
    logic [7:0]  lsb_val = 8'h00;
    int          valid_cnt = 0;
    int          perr_cnt = 0;
    int          start_cnt = 0;
    int          lsb_done_cyc = 0;
    int          valid_cyc = 0;
    logic [7:0]  addr_log[$];

    always @(negedge clk) begin
        cyc++;
        if (temp_valid) begin
            valid_cnt++;
            valid_cyc = cyc;
        end
        if (poll_error) perr_cnt++;
        bus.ctrl_done  = 1'b0;
        bus.ctrl_error = 1'b0;
        bus.ctrl_rdata = 8'hA5;
        if (pending) begin
            if (lat_left == 0) begin
                pending = 1'b0;
                if ((cur_addr == 8'h00) ? err_msb : err_lsb) begin
                    bus.ctrl_error = 1'b1;
                end else begin
                    bus.ctrl_done  = 1'b1;
                    bus.ctrl_rdata = (cur_addr == 8'h00) ? msb_val : lsb_val;
                    if (cur_addr == 8'h01) lsb_done_cyc = cyc;
                end
            end else begin
                lat_left--;
            end
        end
        if (bus.ctrl_start === 1'b1) begin
            start_cnt++;
            addr_log.push_back(bus.ctrl_addr);
            cur_addr = bus.ctrl_addr;
            pending  = 1'b1;
            lat_left = lat_cfg;
        end
        bus.ctrl_busy = busy_force | pending;
    end

    task automatic pulse_poll();
        @(negedge clk) poll_now = 1'b1;
        @(negedge clk) poll_now = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (temp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_perr(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (poll_error) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_start(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ctrl_start) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    typedef struct {
        logic [7:0]  msb;
        logic [7:0]  lsb;
        logic [15:0] raw;
        logic [8:0]  t_int;
        logic [3:0]  t_frac;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_t;
        int start_t;
        int v0;
        int s0;
        int p0;
        int timeouts;
        bit seen;

        vecs[0] = '{msb: 8'h0C, lsb: 8'h80, raw: 16'h0C80, t_int: 9'd25,   t_frac: 4'd0};
        vecs[1] = '{msb: 8'hFF, lsb: 8'hF8, raw: 16'hFFF8, t_int: 9'h1FF,  t_frac: 4'd15};
        vecs[2] = '{msb: 8'hE4, lsb: 8'h88, raw: 16'hE488, t_int: 9'h1C9,  t_frac: 4'd1};
        vecs[3] = '{msb: 8'h4B, lsb: 8'h07, raw: 16'h4B07, t_int: 9'd150,  t_frac: 4'd0};
        vecs[4] = '{msb: 8'h00, lsb: 8'h08, raw: 16'h0008, t_int: 9'd0,    t_frac: 4'd1};

        rst      = 1'b1;
        enable   = 1'b1;
        poll_now = 1'b0;
        msb_val  = 8'h0C;
        lsb_val  = 8'h80;
        repeat (3) @(negedge clk);

        check("rst_start",  32'(bus.ctrl_start), 32'd0);
        check("rst_rw",     32'(bus.ctrl_rw),    32'd1);
        check("rst_addr",   32'(bus.ctrl_addr),  32'h00);
        check("rst_raw",    32'(temp_raw),       32'h0);
        check("rst_int",    32'(temp_int),       32'h0);
        check("rst_frac",   32'(temp_frac),      32'h0);
        check("rst_valid",  32'(temp_valid),     32'd0);
        check("rst_perr",   32'(poll_error),     32'd0);
        check("rst_errcnt", 32'(err_count),      32'd0);
        check("rst_busy",   32'(poller_busy),    32'd0);

        // First automatic poll: leaves IDLE POLL cycles after deassertion.
        addr_log.delete();
        rst     = 1'b0;
        busy_t  = -1;
        start_t = -1;
        for (int t = 1; t <= 200; t++) begin
            @(negedge clk);
            if (poller_busy && busy_t < 0) busy_t = t;
            if (bus.ctrl_start) begin
                start_t = t;
                break;
            end
        end
        check("auto_busy_cycle",  32'(busy_t),  32'(POLL));
        check("auto_start_cycle", 32'(start_t), 32'(POLL + 1));
        wait_valid("auto_valid_timeout");
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("auto_raw",       32'(temp_raw),  32'h0C80);
        check("auto_int",       32'(temp_int),  32'd25);
        check("auto_frac",      32'(temp_frac), 32'd0);
        check("auto_valid_cnt", 32'(valid_cnt), 32'd1);
        check("auto_nlog",      32'(addr_log.size()), 32'd2);
        if (addr_log.size() == 2) begin
            check("auto_addr0", 32'(addr_log[0]), 32'h00);
            check("auto_addr1", 32'(addr_log[1]), 32'h01);
        end
        check("valid_latency", 32'(valid_cyc - lsb_done_cyc), 32'd2);

        foreach (vecs[i]) begin
            v0 = valid_cnt;
            msb_val = vecs[i].msb;
            lsb_val = vecs[i].lsb;
            pulse_poll();
            wait_valid($sformatf("vec%0d_timeout", i));
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_raw", i),   32'(temp_raw),  32'(vecs[i].raw));
            check($sformatf("vec%0d_int", i),   32'(temp_int),  32'(vecs[i].t_int));
            check($sformatf("vec%0d_frac", i),  32'(temp_frac), 32'(vecs[i].t_frac));
            check($sformatf("vec%0d_pulse", i), 32'(valid_cnt - v0), 32'd1);
        end

        // Busy controller delays the request; a poll_now in WAIT_MSB is dropped.
        v0 = valid_cnt;
        s0 = start_cnt;
        msb_val = 8'h19;
        lsb_val = 8'h00;
        busy_force = 1'b1;
        pulse_poll();
        repeat (8) @(negedge clk);
        check("busy_no_start", 32'(start_cnt - s0), 32'd0);
        check("busy_poller",   32'(poller_busy),    32'd1);
        busy_force = 1'b0;
        wait_start("busy_start_timeout");
        pulse_poll();
        wait_valid("busy_valid_timeout");
        repeat (20) @(negedge clk);
        check("busy_starts", 32'(start_cnt - s0), 32'd2);
        check("busy_pulses", 32'(valid_cnt - v0), 32'd1);
        check("busy_raw",    32'(temp_raw),       32'h1900);

        // Error on the LSB read leaves the published value alone.
        v0 = valid_cnt;
        p0 = perr_cnt;
        err_lsb = 1'b1;
        msb_val = 8'h55;
        lsb_val = 8'h55;
        pulse_poll();
        wait_perr(seen);
        check("lsberr_timeout", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        check("lsberr_errcnt", 32'(err_count),      32'd1);
        check("lsberr_pulses", 32'(perr_cnt - p0),  32'd1);
        check("lsberr_raw",    32'(temp_raw),       32'h1900);
        check("lsberr_int",    32'(temp_int),       32'd50);
        check("lsberr_novld",  32'(valid_cnt - v0), 32'd0);
        err_lsb = 1'b0;
        msb_val = 8'h0C;
        lsb_val = 8'h80;
        pulse_poll();
        wait_valid("recover_timeout");
        repeat (2) @(negedge clk);
        check("recover_raw", 32'(temp_raw), 32'h0C80);

        // Reset while waiting on the MSB, with a late done still in flight.
        v0 = valid_cnt;
        lat_cfg = 8;
        pulse_poll();
        wait_start("rstmid_start_timeout");
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("rstmid_idle_next", 32'(poller_busy), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rstmid_novld",  32'(valid_cnt - v0),  32'd0);
        check("rstmid_raw",    32'(temp_raw),        32'h0);
        check("rstmid_int",    32'(temp_int),        32'h0);
        check("rstmid_frac",   32'(temp_frac),       32'h0);
        check("rstmid_errcnt", 32'(err_count),       32'd0);
        check("rstmid_busy",   32'(poller_busy),     32'd0);
        check("rstmid_start",  32'(bus.ctrl_start),  32'd0);
        check("rstmid_addr",   32'(bus.ctrl_addr),   32'h00);
        lat_cfg = 2;

        // Saturating error counter.
        p0 = perr_cnt;
        timeouts = 0;
        err_msb = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            pulse_poll();
            wait_perr(seen);
            if (!seen) timeouts++;
            if (i == 10)  check("sat_cnt10",  32'(err_count), 32'd10);
            if (i == 255) check("sat_cnt255", 32'(err_count), 32'd255);
        end
        repeat (2) @(negedge clk);
        check("sat_timeouts", 32'(timeouts),       32'd0);
        check("sat_final",    32'(err_count),      32'd255);
        check("sat_pulses",   32'(perr_cnt - p0),  32'd260);
        check("sat_raw",      32'(temp_raw),       32'h0);
        err_msb = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_temp_poller.md
# i2c_temp_poller

Periodic ADT7420 temperature acquisition sequencer sitting directly upstream of the I2C controller in `i2c_top`. On a programmable interval, or on demand, it issues two single-byte register reads (temperature MSB at 0x00, then LSB at 0x01) through the controller's start/done handshake. It assembles the 16-bit result and presents it as a signed integer degree value plus a sixteenths fraction to the LED and seven-segment display logic. It is the automatic alternative to the manual BTNR/SW read path.

## Interface
- `POLL_CYCLES`, default 25_000_000: clock cycles between automatic polls (250 ms at 100 MHz).
- `MSB_ADDR`, default 8'h00: temperature MSB register address.
- `LSB_ADDR`, default 8'h01: temperature LSB register address.

Ports:
- `clk`  in  1: system clock (100 MHz).
- `rst`  in  1: synchronous, active-high reset.
- `enable`  in  1: when high, automatic polling runs; when low, the interval counter holds at 0.
- `poll_now`  in  1: single-cycle request for an immediate poll (debounced one-shot).
- `ctrl_busy`  in  1: I2C controller busy.
- `ctrl_done`  in  1: one-cycle pulse; read byte is valid on `ctrl_rdata`.
- `ctrl_error`  in  1: one-cycle pulse; NACK or bus fault, transaction aborted.
- `ctrl_rdata`  in  8: byte returned by the controller.
- `ctrl_start`  out  1: one-cycle transaction request.
- `ctrl_rw`  out  1: read/write select; constant 1 (read).
- `ctrl_addr`  out  8: register address for the current request.
- `temp_raw`  out  16: last good {MSB, LSB}.
- `temp_int`  out  9: signed floor(temperature °C) = `temp_raw[15:7]`.
- `temp_frac`  out  4: sixteenths of a degree = `temp_raw[6:3]`.
- `temp_valid`  out  1: one-cycle pulse when the temperature outputs update.
- `poll_error`  out  1: one-cycle pulse when a poll aborts.
- `err_count`  out  8: saturating count of aborted polls.
- `poller_busy`  out  1: high in every state except IDLE.

## Operation
- States: IDLE, REQ_MSB, WAIT_MSB, REQ_LSB, WAIT_LSB, UPDATE.
- IDLE:
  - The interval counter increments while `enable` is high.
  - A poll is triggered when the counter reaches POLL_CYCLES-1 or when `poll_now` is high. The counter clears when a poll is triggered.
  - Both triggers in the same cycle produce one poll.
  - `poll_now` outside IDLE is ignored; it is not queued.
- REQ_x: waits for `ctrl_busy`=0, then drives `ctrl_start`=1 with `ctrl_addr`=x_ADDR for exactly one cycle and moves to WAIT_x.
- WAIT_MSB:
  - On `ctrl_done`, latch `ctrl_rdata` into a shadow MSB register and go to REQ_LSB.
  - On `ctrl_error`, pulse `poll_error`, increment `err_count` (saturating at 255), and return to IDLE.
  - The visible outputs are unchanged on error.
- WAIT_LSB: same as WAIT_MSB, except that `ctrl_done` goes to UPDATE.
- UPDATE:
  - Loads `temp_raw` = {shadow MSB, LSB}, pulses `temp_valid`, and returns to IDLE.
  - The outputs never show a mixed old/new pair.
- `done` and `error` asserted together: error wins.
- The `ctrl_addr` value holds between requests; it is don't-care outside REQ/WAIT.
- Arithmetic:
  - 13-bit ADT7420 mode; flag bits `temp_raw[2:0]` are ignored.
  - `temp_int` is an arithmetic floor, so negative fractions round toward −∞. Example: −0.0625 °C gives `temp_int`=−1 and `temp_frac`=15.

## Timing
- Reset values:
  - State = IDLE; interval counter = 0.
  - `ctrl_start`=0, `ctrl_rw`=1, `ctrl_addr`=MSB_ADDR.
  - `temp_raw`=0, `temp_int`=0, `temp_frac`=0.
  - `temp_valid`=0, `poll_error`=0, `err_count`=0, `poller_busy`=0.
- Reset mid-transaction returns to IDLE in the next cycle. Any controller done/error pulses arriving afterwards are ignored.
- All outputs are registered.
- `ctrl_start` rises the cycle after entry to REQ_x if `ctrl_busy` is already low.
- `temp_valid` rises exactly 2 cycles after the LSB `ctrl_done` pulse.
- The first automatic poll starts POLL_CYCLES cycles after reset deassertion with `enable` high.

## Structure
- Shared package `i2c_pkg`:
  - State enum `poll_state_t`.
  - ADT7420 register address constants (TEMP_MSB=8'h00, TEMP_LSB=8'h01, STATUS=8'h02, ID=8'h0B).
  - `ADT7420_ADDR`=7'h4B.
- Single module, no sub-modules.
- The interval counter is sized with `$clog2(POLL_CYCLES)`.

## Test plan
- Bench uses POLL_CYCLES=100 with a behavioural controller model.
- Controller returns 0x0C then 0x80 → `temp_raw`=16'h0C80, `temp_int`=25, `temp_frac`=0, one `temp_valid` pulse; `ctrl_addr` sequence is 0x00 then 0x01.
- Controller returns 0xFF then 0xF8 → `temp_int`=−1 (9'h1FF), `temp_frac`=15.
- `ctrl_error` during WAIT_LSB:
  - `poll_error` pulses and `err_count`=1.
  - `temp_raw` is unchanged and no `temp_valid` pulse occurs.
  - The next poll succeeds.
- `poll_now` pulses with `enable`=0:
  - One immediate poll occurs.
  - A second `poll_now` during WAIT_MSB produces no extra `ctrl_start`.
  - Holding `ctrl_busy`=1 delays `ctrl_start` until it drops.
- `rst` asserted in WAIT_MSB, then a late `ctrl_done` arrives → state IDLE, no `temp_valid`, all outputs at reset values.
- 260 forced errors → `err_count` saturates at 255.
